// File: rtl/counter_timer_ctrl.sv
// counter_timer_ctrl
// Programmable interval timer built around a WIDTH-bit up-counter.
// A prescaler divides the clock into ticks, and the counter advances once per tick.
// The timer can run one-shot or auto-reload, and can be paused and resumed.
//
// Ports
//   CLK      : system clock, all state changes on rising edge
//   Rd       : synchronous active-high reset
//   start    : start/restart; latches period, prescale and mode
//   stop     : abort to IDLE (periods is kept)
//   pause    : level, freezes the timer while high
//   mode     : 0 one-shot, 1 auto-reload
//   period   : terminal count; one period is period+1 ticks
//   prescale : one tick every prescale+1 clocks
//   Q        : current count
//   busy     : high in RUN or PAUSE
//   tc       : one-cycle terminal-count pulse
//   done     : one-shot completed, held until start/stop/Rd
//   periods  : completed periods, saturating at 255
//
// state | meaning
// IDLE  | stopped, Q=0
// RUN   | counting prescaled ticks
// PAUSE | frozen, latched values held
// DONE  | one-shot finished, Q=period held
module counter_timer_ctrl #(
  parameter int WIDTH = 8,
  parameter int PS_W  = 4
) (
  input  logic             CLK,
  input  logic             Rd,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  input  logic [PS_W-1:0]  prescale,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic [7:0]       periods
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] q_q, period_q;
  logic [PS_W-1:0]  pc_q, ps_q;
  logic             mode_q, busy_q, tc_q, done_q;
  logic [7:0]       periods_q;

  logic             tick, term;
  logic [PS_W-1:0]  pc_d;
  logic [WIDTH-1:0] q_inc_d;
  logic [7:0]       periods_d;

  always_comb begin
    tick      = (pc_q == ps_q);
    term      = tick && (q_q == period_q);
    pc_d      = tick ? '0 : pc_q + 1'b1;
    q_inc_d   = q_q + 1'b1;
    periods_d = (periods_q == 8'hFF) ? periods_q : periods_q + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (Rd) begin
      state_q   <= S_IDLE;
      q_q       <= '0;
      pc_q      <= '0;
      period_q  <= '0;
      ps_q      <= '0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      tc_q      <= 1'b0;
      done_q    <= 1'b0;
      periods_q <= '0;
    end else if (stop) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      pc_q    <= '0;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else if (start) begin
      // Restart from any state; a coinciding terminal tick is discarded.
      state_q   <= S_RUN;
      period_q  <= period;
      ps_q      <= prescale;
      mode_q    <= mode;
      q_q       <= '0;
      pc_q      <= '0;
      busy_q    <= 1'b1;
      tc_q      <= 1'b0;
      done_q    <= 1'b0;
      periods_q <= '0;
    end else begin
      tc_q <= 1'b0;
      case (state_q)
        S_RUN, S_PAUSE: begin
          if (pause) begin
            state_q <= S_PAUSE;
          end else begin
            // Counting resumes on the same edge pause is seen low, so a
            // pause of N clocks delays the timer by exactly N clocks.
            state_q <= S_RUN;
            pc_q    <= pc_d;
            if (tick) begin
              if (!term) begin
                q_q <= q_inc_d;
              end else begin
                tc_q      <= 1'b1;
                periods_q <= periods_d;
                if (mode_q) begin
                  q_q <= '0;
                end else begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign Q       = q_q;
  assign busy    = busy_q;
  assign tc      = tc_q;
  assign done    = done_q;
  assign periods = periods_q;

endmodule

// File: tb/tb_counter_timer_ctrl.sv
module tb_counter_timer_ctrl;

  logic       clk = 1'b0;
  logic       rd = 1'b0, st = 1'b0, stp = 1'b0, pz = 1'b0, md = 1'b0;
  logic [7:0] per = '0;
  logic [3:0] psc = '0;
  logic [7:0] q;
  logic       busy, tc, done;
  logic [7:0] periods;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: elapsed counting clocks since the last accepted start.
  bit m_run = 0, m_done = 0, m_tc = 0, m_mode = 0;
  int m_act = 0, m_per = 0, m_ps = 0, m_periods = 0;

  counter_timer_ctrl #(.WIDTH(8), .PS_W(4)) dut (
    .CLK(clk), .Rd(rd), .start(st), .stop(stp), .pause(pz), .mode(md),
    .period(per), .prescale(psc),
    .Q(q), .busy(busy), .tc(tc), .done(done), .periods(periods)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] exp_vec();
    int eq;
    if (m_run)       eq = (m_act / (m_ps + 1)) % (m_per + 1);
    else if (m_done) eq = m_per;
    else             eq = 0;
    return {eq[7:0], m_run, m_tc, m_done, m_periods[7:0]};
  endfunction

  function automatic logic [18:0] obs_vec();
    return {q, busy, tc, done, periods};
  endfunction

  task automatic model_edge();
    int len;
    m_tc = 0;
    if (rd) begin
      m_run = 0; m_done = 0; m_act = 0; m_per = 0; m_ps = 0; m_mode = 0; m_periods = 0;
    end else if (stp) begin
      m_run = 0; m_done = 0; m_act = 0;
    end else if (st) begin
      m_per = per; m_ps = psc; m_mode = md;
      m_run = 1; m_done = 0; m_act = 0; m_periods = 0;
    end else if (m_run && !pz) begin
      m_act++;
      len = (m_per + 1) * (m_ps + 1);
      m_tc = (m_act % len) == 0;
      m_periods = (m_act / len > 255) ? 255 : m_act / len;
      if (!m_mode && m_act == len) begin
        m_run = 0; m_done = 1;
      end
    end
  endtask

  task automatic step(input logic r, input logic s, input logic sp, input logic p,
                      input logic m, input logic [7:0] pv, input logic [3:0] sv);
    rd = r; st = s; stp = sp; pz = p; md = m; per = pv; psc = sv;
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 0, 0, 1, 8'd7, 4'd3);
      total++;
      if (obs_vec() !== 19'd0) begin
        bad++;
        $display("FAIL reset cyc=%0d got=%h want=0", cyc, obs_vec());
      end
    end
  endtask

  task automatic test_autoreload();
    int ntc = 0;
    step(0, 1, 0, 0, 1, 8'd3, 4'd0);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0, 0, 8'd9, 4'd5);
      if (tc) ntc++;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL autoreload cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    total++;
    if (ntc != 3 || periods !== 8'd3) begin
      bad++;
      $display("FAIL autoreload_tc_count got=%0d/%0d want=3/3", ntc, periods);
    end
  endtask

  task automatic test_oneshot();
    int tc_at = -1;
    step(0, 1, 0, 0, 0, 8'd2, 4'd2);
    for (int i = 1; i <= 20; i++) begin
      step(0, 0, 0, 0, 0, 8'd0, 4'd0);
      if (tc) tc_at = i;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL oneshot cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    total++;
    if (tc_at != 9 || q !== 8'd2 || done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL oneshot_end tc_at=%0d q=%0d done=%b busy=%b want 9/2/1/0", tc_at, q, done, busy);
    end
  endtask

  task automatic test_pause();
    int n = 0;
    bit seen = 0;
    step(0, 1, 0, 0, 1, 8'd10, 4'd1);
    for (int i = 0; i < 10; i++) begin step(0, 0, 0, 0, 0, 8'd0, 4'd0); n++; end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 0, 8'd0, 4'd0); n++;
      total++;
      if (q !== 8'd5 || tc !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL pause_hold cyc=%0d q=%0d tc=%b want q=5 tc=0", cyc, q, tc);
      end
    end
    while (!seen && n < 100) begin
      step(0, 0, 0, 0, 0, 8'd0, 4'd0); n++;
      seen = tc;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL pause_run cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    total++;
    if (n != 27) begin
      bad++;
      $display("FAIL pause_tc_time got=%0d want=27", n);
    end
  endtask

  task automatic test_restart_on_tc();
    step(0, 1, 0, 0, 1, 8'd3, 4'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 8'd0, 4'd0);
    step(0, 1, 0, 0, 1, 8'd1, 4'd0);
    total++;
    if (tc !== 1'b0 || q !== 8'd0 || periods !== 8'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_edge got tc=%b q=%0d periods=%0d want 0/0/0", tc, q, periods);
    end
    for (int i = 1; i <= 6; i++) begin
      step(0, 0, 0, 0, 0, 8'd0, 4'd0);
      total++;
      if (tc !== ((i % 2) == 0) || obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL restart_run cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_saturation();
    step(0, 1, 0, 0, 1, 8'd0, 4'd0);
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 0, 0, 0, 8'd0, 4'd0);
      total++;
      if (tc !== 1'b1 || obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL saturate cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    step(0, 0, 1, 0, 0, 8'd0, 4'd0);
    total++;
    if (q !== 8'd0 || periods !== 8'd255 || busy !== 1'b0 || tc !== 1'b0) begin
      bad++;
      $display("FAIL stop_keep q=%0d periods=%0d busy=%b want 0/255/0", q, periods, busy);
    end
  endtask

  task automatic test_random();
    logic [7:0] pv;
    for (int i = 0; i < 3000; i++) begin
      pv = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
           1'($urandom), pv, 4'($urandom_range(0, 3)));
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_autoreload();
    test_oneshot();
    test_pause();
    test_restart_on_tc();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
